// File: rtl/cpu_csr_seq.sv
// cpu_csr_seq: CSR port sequencer for instruction CSR ops, trap entry and sret
// Ports: clk, rst_n (async active-low); inst_req/op/addr/wdata -> inst_ack/rdata;
//        trap_req/sret_req with trap_cause/epc/tval -> done/target_pc; priv, busy;
//        csr_addr/csr_wdata/csr_wr/csr_rdata drive the shared CSR file port.
// Optional: define CSR_SEQ_VECTORED_EN to enable vectored interrupt targets.
module cpu_csr_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_req,
   input  logic [1:0]  inst_op,
   input  logic [11:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_ack,
   output logic [31:0] inst_rdata,
   input  logic        trap_req,
   input  logic        sret_req,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_epc,
   input  logic [31:0] trap_tval,
   output logic        done,
   output logic [31:0] target_pc,
   output logic        priv,
   output logic        busy,
   output logic [11:0] csr_addr,
   output logic [31:0] csr_wdata,
   output logic        csr_wr,
   input  logic [31:0] csr_rdata
);
   typedef enum logic [3:0] {
      IDLE, I_RD, I_WR, T_EPC, T_CAUSE, T_TVAL, T_SRD, T_SWR, T_VEC,
      R_SRD, R_SWR, R_EPC, DONE
   } state_t;
   state_t state, nxt;
   logic [1:0]  op;
   logic [11:0] addr;
   logic [31:0] wdata, cause, epc, tval, sts, vec_pc;
`ifdef CSR_SEQ_VECTORED_EN
   assign vec_pc = (csr_rdata[1:0] == 2'b01 && cause[31]) ?
                   {csr_rdata[31:2], 2'b00} + {cause[29:0], 2'b00} :
                   {csr_rdata[31:2], 2'b00};
`else
   assign vec_pc = {csr_rdata[31:2], 2'b00};
`endif
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = trap_req ? T_EPC : sret_req ? R_SRD : inst_req ? I_RD : IDLE;
         I_RD:    nxt = I_WR;
         T_EPC:   nxt = T_CAUSE;
         T_CAUSE: nxt = T_TVAL;
         T_TVAL:  nxt = T_SRD;
         T_SRD:   nxt = T_SWR;
         T_SWR:   nxt = T_VEC;
         T_VEC:   nxt = DONE;
         R_SRD:   nxt = R_SWR;
         R_SWR:   nxt = R_EPC;
         R_EPC:   nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   // sstatus bits: SIE[1], SPIE[5], SPP[8]
   always_comb begin
      csr_addr  = '0;
      csr_wdata = '0;
      csr_wr    = 1'b0;
      case (state)
         I_RD: csr_addr = addr;
         I_WR: begin
            csr_addr  = addr;
            csr_wdata = !op[1] ? wdata : !op[0] ? (inst_rdata | wdata) : (inst_rdata & ~wdata);
            csr_wr    = !op[1] || |wdata;
         end
         T_EPC:   begin csr_addr = 12'h141; csr_wdata = epc;   csr_wr = 1'b1; end
         T_CAUSE: begin csr_addr = 12'h142; csr_wdata = cause; csr_wr = 1'b1; end
         T_TVAL:  begin csr_addr = 12'h143; csr_wdata = tval;  csr_wr = 1'b1; end
         T_SRD, R_SRD: csr_addr = 12'h100;
         T_SWR: begin
            csr_addr  = 12'h100;
            csr_wdata = {sts[31:9], priv, sts[7:6], sts[1], sts[4:2], 1'b0, sts[0]};
            csr_wr    = 1'b1;
         end
         R_SWR: begin
            csr_addr  = 12'h100;
            csr_wdata = {sts[31:9], 1'b0, sts[7:6], 1'b1, sts[4:2], sts[5], sts[0]};
            csr_wr    = 1'b1;
         end
         T_VEC: csr_addr = 12'h105;
         R_EPC: csr_addr = 12'h141;
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         inst_ack   <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         inst_rdata <= '0;
         target_pc  <= '0;
         priv       <= 1'b1;
         op         <= '0;
         addr       <= '0;
         wdata      <= '0;
         cause      <= '0;
         epc        <= '0;
         tval       <= '0;
         sts        <= '0;
      end else begin
         state    <= nxt;
         inst_ack <= nxt == I_WR;
         done     <= nxt == DONE;
         busy     <= nxt != IDLE;
         // operands only matter on the accepting edge, so sampling every idle cycle is harmless
         if (state == IDLE) begin
            op    <= inst_op;
            addr  <= inst_addr;
            wdata <= inst_wdata;
            cause <= trap_cause;
            epc   <= trap_epc;
            tval  <= trap_tval;
         end
         if (state == I_RD) inst_rdata <= csr_rdata;
         if (state == T_SRD || state == R_SRD) sts <= csr_rdata;
         if (state == T_SWR) priv <= 1'b1;
         if (state == R_SWR) priv <= sts[8];
         if (state == T_VEC) target_pc <= vec_pc;
         if (state == R_EPC) target_pc <= {csr_rdata[31:2], 2'b00};
      end
   end
endmodule

// File: doc/cpu_csr_seq.md
# cpu_csr_seq

CSR access sequencer for the CPU core. It owns the single address/data/write port of the CSR file and shares it between two requesters: instruction CSR operations (csrrw/csrrs/csrrc) and the trap unit (trap entry and sret). It sequences the multi-register updates a trap needs, computes the handler or return PC, and tracks the current privilege level.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- inst_req  in  1  instruction CSR request; held until inst_ack
- inst_op  in  2  01 = RW, 10 = RS (set), 11 = RC (clear); 00 is treated as RW
- inst_addr  in  12  CSR address
- inst_wdata  in  32  rs1/immediate operand
- inst_ack  out  1  one-cycle completion strobe
- inst_rdata  out  32  old CSR value, registered, valid from inst_ack onward
- trap_req  in  1  trap entry request; held until done
- sret_req  in  1  sret request; held until done
- trap_cause  in  32  scause value; bit 31 marks an interrupt
- trap_epc  in  32  faulting or interrupted PC
- trap_tval  in  32  stval value
- done  out  1  one-cycle completion strobe for trap_req or sret_req
- target_pc  out  32  registered; handler PC or return PC, valid while done is high
- priv  out  1  current privilege, 1 = S, 0 = U
- busy  out  1  state is not IDLE
- csr_addr  out  12  CSR file address
- csr_wdata  out  32  CSR file write data
- csr_wr  out  1  CSR file write enable
- csr_rdata  in  32  CSR file combinational read data

## Operation
- **States:** IDLE, I_RD, I_WR, T_EPC, T_CAUSE, T_TVAL, T_SRD, T_SWR, T_VEC, R_SRD, R_SWR, R_EPC, DONE.
- **Arbitration in IDLE:** priority is trap_req, then sret_req, then inst_req. Accepted operands (op, addr, wdata, cause, epc, tval) are captured into internal registers at acceptance. An operation in progress is never aborted.
- **Instruction path:**
  - I_RD: csr_addr = inst_addr; csr_rdata is latched into inst_rdata.
  - I_WR: csr_wdata is wdata for RW, old|wdata for RS, old&~wdata for RC.
  - For RS/RC with wdata == 0, csr_wr stays 0 (no write).
  - inst_ack is high during I_WR; the next state is IDLE.
- **Trap path:**
  - T_EPC writes 0x141 (sepc) = epc.
  - T_CAUSE writes 0x142 (scause) = cause.
  - T_TVAL writes 0x143 (stval) = tval.
  - T_SRD reads 0x100 (sstatus) into a holding register.
  - T_SWR writes sstatus with SPIE[5] ← SIE[1], SIE[1] ← 0, SPP[8] ← priv; priv ← 1.
  - T_VEC reads 0x105 (stvec) and registers target_pc; the next state is DONE.
- **sret path:**
  - R_SRD reads sstatus.
  - R_SWR writes SIE ← SPIE, SPIE ← 1, SPP ← 0; priv ← old SPP.
  - R_EPC reads sepc and registers target_pc = sepc & ~3; the next state is DONE.
- **DONE:** done is high; the next state is IDLE.
- **Port outputs:** csr_addr, csr_wdata and csr_wr are decoded combinationally from the state and captured operands. csr_wr is high only in the I_WR, T_EPC, T_CAUSE, T_TVAL, T_SWR and R_SWR states. The CSR read path is independent of csr_wdata, so there is no combinational loop.
- **Arithmetic:** all 32-bit, modulo 2^32; no overflow flag.

## Timing
- **Reset:** rst_n low asynchronously forces state IDLE and clears inst_ack, done, busy, csr_wr, csr_addr, csr_wdata, inst_rdata and target_pc to 0. priv resets to 1. Reset mid-sequence abandons the sequence; CSR writes already performed stand.
- **Latency:** counted from the acceptance edge (request sampled high in IDLE).
  - inst_ack is high in cycle +2.
  - Trap done is high in cycle +7.
  - sret done is high in cycle +4.
- **Handshake:** inst_ack and done are Moore outputs. The requester drops its request on the edge that ends the strobe cycle. The block is in IDLE on the following cycle and never re-accepts the same request.
- **Simultaneous events:**
  - trap_req and inst_req both high in IDLE: the trap is served first; the instruction is accepted in the IDLE cycle after DONE.
  - trap_req arriving during an instruction sequence waits until after inst_ack.
  - trap_req and sret_req both high: the trap wins.

## Configuration
- **CSR_SEQ_VECTORED_EN**
  - Defined: stvec MODE[1:0] == 01 with trap_cause[31] = 1 gives target_pc = (stvec & ~3) + 4·cause[30:0]. Any other MODE or cause gives direct mode.
  - Undefined: MODE is ignored; target_pc = stvec & ~3 always.

## Test plan
- **RS read-modify-write:** CSR model sscratch = 0x0000_00F0; inst RS, addr 0x140, wdata 0x0F → inst_rdata = 0xF0, one write of 0xFF, inst_ack in cycle +2.
- **RC with zero operand:** RC with wdata 0 on 0x140 → csr_wr never asserted; inst_rdata = current value.
- **Trap entry from U-mode:** priv = 0, sstatus = 0x2, stvec = 0x8000_0000, cause 0x2, epc 0x1234, tval 0xDEAD.
  - sepc/scause/stval written in order.
  - sstatus becomes 0x20; priv = 1.
  - done at +7 with target_pc = 0x8000_0000.
- **Vectored interrupt (macro defined):** stvec = 0x8000_0001, cause 0x8000_0005 → target_pc = 0x8000_0014. Same stimulus with the macro undefined → 0x8000_0000.
- **sret:** sstatus = 0x20 (SPP = 0), sepc = 0x1236 → sstatus written 0x22, priv = 0, target_pc = 0x1234, done at +4.
- **Contention and reset:**
  - trap_req and inst_req raised together → trap done precedes inst_ack.
  - rst_n pulsed low during T_TVAL → all outputs 0 immediately, priv = 1, state IDLE.
